// File: rtl/shiftreg_seq_ctrl.sv
// Sequencer for a WIDTH-bit parallel-in shift register.
// Accepts a word over a valid/ready handshake, strobes a load, then issues a
// programmed number of shift strobes while returning the Q0 bit stream
// (LSB first). Every output is registered on posedge CLK so it is stable
// by the following negedge, which is when the shift register samples.
module shiftreg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [2:0]       IN_COUNT,
    input  logic             IN_ROT,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [WIDTH-1:0] D_OUT,
    output logic             L,
    output logic             SH,
    output logic             SI,
    output logic             BIT_OUT,
    output logic             BIT_VALID,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    // Value loaded into the gap counter on entry to GAP; counts down to 0.
    localparam logic [2:0] GAP_LAST = 3'((GAP > 0) ? (GAP - 1) : 0);

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [2:0] gap_q;
    logic       rot_q;

    // Only Q0 is observed; the upper register bits are not needed here.
    logic q_upper_unused;
    assign q_upper_unused = ^Q_IN[WIDTH-1:1];

    // Controller FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            gap_q     <= 3'd0;
            rot_q     <= 1'b0;
            IN_READY  <= 1'b1;
            D_OUT     <= '0;
            L         <= 1'b0;
            SH        <= 1'b0;
            SI        <= 1'b0;
            BIT_OUT   <= 1'b0;
            BIT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            L         <= 1'b0;
            SH        <= 1'b0;
            SI        <= 1'b0;
            BIT_VALID <= 1'b0;
            DONE      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        D_OUT    <= IN_DATA;
                        cnt_q    <= IN_COUNT;
                        rot_q    <= IN_ROT;
                        L        <= 1'b1;
                        IN_READY <= 1'b0;
                        BUSY     <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                // LOAD and SHIFT share the decision: shift again while shifts
                // remain, otherwise finish the word. Q_IN here reflects the
                // register after the previous negedge (load or shift).
                S_LOAD, S_SHIFT: begin
                    if (cnt_q != 3'd0) begin
                        SH        <= 1'b1;
                        BIT_VALID <= 1'b1;
                        BIT_OUT   <= Q_IN[0];
                        SI        <= rot_q & Q_IN[0];
                        cnt_q     <= cnt_q - 3'd1;
                        state_q   <= S_SHIFT;
                    end else begin
                        DONE <= 1'b1;
                        if (GAP == 0) begin
                            IN_READY <= 1'b1;
                            BUSY     <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            gap_q   <= GAP_LAST;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == 3'd0) begin
                        IN_READY <= 1'b1;
                        BUSY     <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Bench for shiftreg_seq_ctrl: two controllers (GAP=1 and GAP=0), each driving
// its own negedge shift register model. Expected events are queued when a word
// is issued and a per-instance monitor pops them as the DUT presents outputs.
module tb_shiftreg_seq_ctrl;

    localparam int W = 4;

    typedef struct {
        int           cyc;
        logic [W-1:0] v;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fin    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic ev_t mk(input int c, input logic [W-1:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        return e;
    endfunction

    // Bit k of the serial stream seen at Q0 after the load (k = 0 is D0).
    function automatic logic ref_bit(input logic [W-1:0] d, input int k, input bit rot);
        if (rot) return d[k % W];
        return (k < W) ? d[k] : 1'b0;
    endfunction

    // After n shifts, Qi holds stream element n+i.
    function automatic logic [W-1:0] ref_final(input logic [W-1:0] d, input int n, input bit rot);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = ref_bit(d, i + n, rot);
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int GP = (g == 0) ? 1 : 0;

        logic         rst      = 1'b1;
        logic         in_valid = 1'b0;
        logic [W-1:0] in_data  = '0;
        logic [2:0]   in_count = 3'd0;
        logic         in_rot   = 1'b0;
        logic         in_ready, l, sh, si, bit_out, bit_valid, busy, done;
        logic [W-1:0] d_out;
        logic [W-1:0] q_reg = '0;
        ev_t          lq[$];
        ev_t          bq[$];
        ev_t          dq[$];
        ev_t          rq[$];
        bit           prev_ready = 1'b1;

        shiftreg_seq_ctrl #(.WIDTH(W), .GAP(GP)) dut (
            .CLK      (clk),
            .RST      (rst),
            .IN_VALID (in_valid),
            .IN_READY (in_ready),
            .IN_DATA  (in_data),
            .IN_COUNT (in_count),
            .IN_ROT   (in_rot),
            .Q_IN     (q_reg),
            .D_OUT    (d_out),
            .L        (l),
            .SH       (sh),
            .SI       (si),
            .BIT_OUT  (bit_out),
            .BIT_VALID(bit_valid),
            .BUSY     (busy),
            .DONE     (done)
        );

        // Shift register: acts on negedge; shifts toward Q0 with SI entering at Q3.
        always @(negedge clk) begin
            if (l) q_reg <= d_out;
            else if (sh) q_reg <= {si, q_reg[W-1:1]};
        end

        // Monitor: compare DUT events against queued expectations.
        initial begin : mon
            ev_t e;
            forever begin
                @(negedge clk);
                if (rst) begin
                    lq.delete();
                    bq.delete();
                    dq.delete();
                    rq.delete();
                    prev_ready = 1'b1;
                end else begin
                    check("L_SH_exclusive", 32'(l & sh), 0);
                    check("ready_vs_busy", 32'(in_ready), 32'(!busy));
                    if (l) begin
                        if (lq.size() == 0) check("unexpected_L", cyc, 0);
                        else begin
                            e = lq.pop_front();
                            check("L_cycle", cyc, e.cyc);
                            check("D_OUT", 32'(d_out), 32'(e.v));
                        end
                    end else if (lq.size() != 0 && lq[0].cyc <= cyc) begin
                        check("missing_L", cyc, lq[0].cyc);
                        void'(lq.pop_front());
                    end
                    if (bit_valid) begin
                        if (bq.size() == 0) check("unexpected_bit", cyc, 0);
                        else begin
                            e = bq.pop_front();
                            check("bit_cycle", cyc, e.cyc);
                            check("BIT_OUT", 32'(bit_out), 32'(e.v[0]));
                            check("SI", 32'(si), 32'(e.v[1]));
                            check("SH_with_bit", 32'(sh), 1);
                        end
                    end else if (bq.size() != 0 && bq[0].cyc <= cyc) begin
                        check("missing_bit", cyc, bq[0].cyc);
                        void'(bq.pop_front());
                    end
                    if (done) begin
                        if (dq.size() == 0) check("unexpected_DONE", cyc, 0);
                        else begin
                            e = dq.pop_front();
                            check("DONE_cycle", cyc, e.cyc);
                            check("final_reg", 32'(q_reg), 32'(e.v));
                        end
                    end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                        check("missing_DONE", cyc, dq[0].cyc);
                        void'(dq.pop_front());
                    end
                    if (in_ready && !prev_ready) begin
                        if (rq.size() == 0) check("unexpected_ready", cyc, 0);
                        else begin
                            e = rq.pop_front();
                            check("ready_cycle", cyc, e.cyc);
                        end
                    end else if (!in_ready && rq.size() != 0 && rq[0].cyc <= cyc) begin
                        check("missing_ready", cyc, rq[0].cyc);
                        void'(rq.pop_front());
                    end
                    prev_ready = in_ready;
                end
            end
        end

        // Offer a word (called at a negedge), queue its expected events, return at the LOAD negedge.
        task automatic send(input logic [W-1:0] d, input logic [2:0] c, input bit r);
            int           t;
            int           ld;
            logic         b;
            logic [W-1:0] bv;
            t        = 0;
            in_valid = 1'b1;
            in_data  = d;
            in_count = c;
            in_rot   = r;
            while (!in_ready && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("accept_timeout", 0, 1);
            end else begin
                ld = cyc + 1;
                lq.push_back(mk(ld, d));
                for (int k = 0; k < int'(c); k++) begin
                    b     = ref_bit(d, k, r);
                    bv    = '0;
                    bv[0] = b;
                    bv[1] = r ? b : 1'b0;
                    bq.push_back(mk(ld + 1 + k, bv));
                end
                dq.push_back(mk(ld + 1 + int'(c), ref_final(d, int'(c), r)));
                rq.push_back(mk(ld + 1 + int'(c) + GP, '0));
                @(negedge clk);
            end
            in_valid = 1'b0;
        endtask

        // Pulse IN_VALID with junk data while the controller is busy.
        task automatic poke_while_busy();
            for (int k = 0; k < 64 && !in_ready; k++) begin
                in_valid = (k % 2 == 0);
                in_data  = 4'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b0;
        endtask

        task automatic chk_reset(input string tag);
            check({tag, "_IN_READY"}, 32'(in_ready), 1);
            check({tag, "_L"}, 32'(l), 0);
            check({tag, "_SH"}, 32'(sh), 0);
            check({tag, "_SI"}, 32'(si), 0);
            check({tag, "_D_OUT"}, 32'(d_out), 0);
            check({tag, "_BIT_OUT"}, 32'(bit_out), 0);
            check({tag, "_BIT_VALID"}, 32'(bit_valid), 0);
            check({tag, "_BUSY"}, 32'(busy), 0);
            check({tag, "_DONE"}, 32'(done), 0);
        endtask

        // Stimulus: directed words, mid-word reset, back-to-back, then random words.
        initial begin : drv
            int n;
            repeat (2) @(negedge clk);
            chk_reset("por");
            rst = 1'b0;
            @(negedge clk);
            send(4'b1011, 3'd4, 1'b0);
            send(4'b0110, 3'd7, 1'b1);
            poke_while_busy();
            send(4'hA, 3'd0, 1'b0);
            poke_while_busy();
            send(4'b1101, 3'd5, 1'b1);
            repeat (3) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk_reset("midword");
            repeat (2) @(negedge clk);
            rst = 1'b0;
            #1;
            check("ready_at_release", 32'(in_ready), 1);
            @(negedge clk);
            send(4'b0101, 3'd3, 1'b0);
            send(4'h3, 3'd4, 1'b0);
            send(4'hC, 3'd4, 1'b0);
            for (int i = 0; i < 40; i++) begin
                send(4'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) poke_while_busy();
                else repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            n = 0;
            for (int t = 0; t < 200 && (lq.size() + bq.size() + dq.size() + rq.size()) != 0; t++) begin
                @(negedge clk);
            end
            n = lq.size() + bq.size() + dq.size() + rq.size();
            check("drain", n, 0);
            n_fin++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && n_fin < 2; t++) @(posedge clk);
        check("run_complete", n_fin, 2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
